uart_rx_8n1: RTL and testbench
==============================

# uart_rx_8n1

UART 8N1 serial receiver with a fixed-ratio oversampling clock. It sits directly upstream of the Hamming(7,4) decoder path. It turns the asynchronous line on the dedicated input pin into framed bytes with a one-cycle valid strobe and a framing-error flag. The Hamming codeword is carried in `data_out[6:0]`; `data_out[7]` is passed through for the top level to ignore or display.

## Interface
- `OVERSAMPLE`, default 8: clocks per bit period. Must be a power of two and ≥ 4. All counter widths are derived from it.
- `clk` input 1: the single clock, running at OVERSAMPLE × baud rate.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ena` input 1: counting enable. When low, the receiver is frozen.
- `rx_in` input 1: serial line. Idle high, LSB first.
- `data_out` output 8: last correctly framed byte.
- `data_valid` output 1: one-cycle pulse when `data_out` is updated.
- `frame_err` output 1: high if the most recent stop bit sampled low.
- `busy` output 1: high whenever the state is not IDLE.
- `debug_state_out` output 2: FSM state encoding. IDLE=0, START=1, DATA=2, STOP=3.
- `debug_bit_cnt_out` output 3: current data bit index.

## Operation
- Synchronizer:
  - `rx_in` passes through 2 flops into `rx_s`, then 1 flop into `rx_prev`.
  - All three reset to 1.
  - They run every clock, regardless of `ena`.
- FSM and counters:
  - `os_cnt` is log2(OVERSAMPLE) bits wide. `bit_cnt` is 3 bits. The shift register `shreg` is 8 bits.
  - These advance only on cycles with `ena`=1. With `ena`=0 they hold, and `data_valid` is 0.
- IDLE:
  - Start condition: `rx_prev`=1 and `rx_s`=0 (a falling edge). It moves to START with `os_cnt`=0.
  - A line that is held low (break) never re-triggers. It needs a return to high first.
- START:
  - `os_cnt` increments each cycle.
  - When `os_cnt`==OVERSAMPLE/2−1, `rx_s` is checked:
    - 0 → DATA, with `os_cnt`=0 and `bit_cnt`=0.
    - 1 → false start. Return to IDLE with no output change.
- DATA:
  - When `os_cnt`==OVERSAMPLE−1, `rx_s` shifts in at the MSB: `shreg` <= {`rx_s`, `shreg`[7:1]}. At the same time `os_cnt` resets to 0 and `bit_cnt` increments.
  - When this sample happens with `bit_cnt`==7, the FSM goes to STOP. `bit_cnt` wraps to 0.
- STOP:
  - When `os_cnt`==OVERSAMPLE−1, `rx_s` is checked:
    - 1 → `data_out` <= `shreg`, `data_valid` pulses, `frame_err` <= 0.
    - 0 → `frame_err` <= 1. `data_out` holds and there is no pulse.
  - Either way, the FSM returns to IDLE.
- `frame_err` is level-held. It changes only at stop-bit samples or on reset.
- `busy` = (state ≠ IDLE).
- Reset values: `data_out`=0x00, `data_valid`=0, `frame_err`=0, `busy`=0, state=IDLE, `bit_cnt`=0, `os_cnt`=0, `shreg`=0.

## Timing
- Sample points, with `ena` held high:
  - Start-bit centre: OVERSAMPLE/2 cycles after START entry.
  - Each data bit and the stop bit: OVERSAMPLE cycles after the previous sample.
- Latency: let edge 0 be the first clock edge that samples `rx_in` low.
  - START is entered at edge 2.
  - `data_valid` is registered at edge 2 + OVERSAMPLE/2 + 9·OVERSAMPLE. For OVERSAMPLE=8 this is edge 78, and `data_valid` is high from edge 78 to edge 79.
- Back-to-back frames: the next start edge can be detected on the first cycle after the return to IDLE. No idle gap beyond the stop bit is required.
- `data_out` is stable from its update until the next good frame.
- Deasserting `ena` mid-frame stretches the frame by exactly the number of stalled cycles. Samples shift accordingly.
- Asserting `rst_n` low mid-frame aborts immediately. After release, the receiver waits in IDLE for a fresh falling edge. A line still low at release does not start a frame.

## Test plan
- Byte 0x5A, OVERSAMPLE=8, `ena`=1, stop bit=1 → `data_valid` pulses for exactly 1 cycle at edge 78. `data_out`=0x5A. `frame_err`=0. `busy` is low on the following cycle.
- Byte 0xC3, then 0x0F sent back-to-back with no idle gap → two pulses 80 cycles apart, carrying 0xC3 then 0x0F. No `frame_err`.
- Glitch: `rx_in` low for 2 clocks, then high → START aborts at the mid-bit check. Returns to IDLE. No `data_valid`, `data_out` unchanged.
- Byte 0xA5 with stop bit=0 → `frame_err`=1, no `data_valid`, `data_out` keeps the previous value. A following good 0x11 frame → `data_out`=0x11 and `frame_err`=0.
- `ena` low for 5 cycles in the middle of bit 3 of byte 0x96 → `data_out`=0x96, with `data_valid` at edge 83.
- `rst_n` pulsed low during bit 4, with `rx_in` released high afterwards → all outputs return to reset values. The next clean 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_8n1
//  Brief    : 8N1 UART receiver, OVERSAMPLE clocks per bit, framed-byte strobe
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_8n1 #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] debug_state_out,
  output logic [2:0] debug_bit_cnt_out
);

  localparam int c_os_w = $clog2(OVERSAMPLE);
  localparam logic [c_os_w-1:0] c_os_half = c_os_w'(OVERSAMPLE/2 - 1);
  localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OVERSAMPLE - 1);
  localparam logic [c_os_w-1:0] c_os_one  = c_os_w'(1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_data  = 2'd2;
  localparam logic [1:0] c_st_stop  = 2'd3;

  logic              r_rx_meta;
  logic              r_rx_s;
  logic              r_rx_prev;
  logic [2:0]        r_fill;
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [c_os_w-1:0] r_os_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shreg;
  logic [7:0]        r_data_out;
  logic              r_data_valid;
  logic              r_frame_err;
  logic              w_start;
  logic              w_os_half;
  logic              w_os_last;

  // r_fill marks when the sync chain holds real line samples instead of its
  // reset ones, so a line still low at reset release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_fill    <= 3'b000;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_fill    <= {r_fill[1:0], 1'b1};
    end
  end

  assign w_start   = r_fill[2] & r_rx_prev & ~r_rx_s;
  assign w_os_half = (r_os_cnt == c_os_half);
  assign w_os_last = (r_os_cnt == c_os_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ena) begin
      case (r_state)
        c_st_idle:  if (w_start) w_state_nxt = c_st_start;
        c_st_start: if (w_os_half) w_state_nxt = r_rx_s ? c_st_idle : c_st_data;
        c_st_data:  if (w_os_last && (r_bit_cnt == 3'd7)) w_state_nxt = c_st_stop;
        c_st_stop:  if (w_os_last) w_state_nxt = c_st_idle;
        default:    w_state_nxt = c_st_idle;
      endcase
    end
  end

  always_comb begin
    busy              = (r_state != c_st_idle);
    debug_state_out   = r_state;
    debug_bit_cnt_out = r_bit_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_os_cnt     <= '0;
      r_bit_cnt    <= 3'd0;
      r_shreg      <= 8'h00;
      r_data_out   <= 8'h00;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (ena) begin
        case (r_state)
          c_st_idle: begin
            if (w_start) r_os_cnt <= '0;
          end
          c_st_start: begin
            if (w_os_half) begin
              r_os_cnt  <= '0;
              r_bit_cnt <= 3'd0;
            end else begin
              r_os_cnt <= r_os_cnt + c_os_one;
            end
          end
          c_st_data: begin
            if (w_os_last) begin
              r_shreg   <= {r_rx_s, r_shreg[7:1]};
              r_os_cnt  <= '0;
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end else begin
              r_os_cnt <= r_os_cnt + c_os_one;
            end
          end
          default: begin
            // Stop-bit sample: a low stop bit flags the frame and keeps the old byte.
            if (w_os_last) begin
              r_os_cnt <= '0;
              if (r_rx_s) begin
                r_data_out   <= r_shreg;
                r_data_valid <= 1'b1;
                r_frame_err  <= 1'b0;
              end else begin
                r_frame_err <= 1'b1;
              end
            end else begin
              r_os_cnt <= r_os_cnt + c_os_one;
            end
          end
        endcase
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_8n1
//  Brief    : directed self-checking bench for uart_rx_8n1 (OVERSAMPLE = 8)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_8n1;

  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;
  logic [1:0] debug_state_out;
  logic [2:0] debug_bit_cnt_out;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0;
  int pulse_cyc[$];
  int pulse_dat[$];

  uart_rx_8n1 #(.OVERSAMPLE(OS)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ena               (ena),
    .rx_in             (rx_in),
    .data_out          (data_out),
    .data_valid        (data_valid),
    .frame_err         (frame_err),
    .busy              (busy),
    .debug_state_out   (debug_state_out),
    .debug_bit_cnt_out (debug_bit_cnt_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every strobe with the index of the edge that registered it.
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(int'(data_out));
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    ena   = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Line time only advances on enabled cycles, so a stall stretches the frame.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stall_at,
                            input int stall_len, input int ncyc, output int t_edge0);
    logic [9:0] bits;
    int k;
    int e;
    bits    = {stop, b, 1'b0};
    k       = 0;
    e       = 0;
    t_edge0 = 0;
    while (k < ncyc) begin
      rx_in = bits[k / OS];
      ena   = !((e >= stall_at) && (e < stall_at + stall_len));
      @(negedge clk);
      if (e == 0) t_edge0 = cyc;
      if (ena) k++;
      e++;
    end
    ena = 1'b1;
  endtask

  task automatic clear_pulses();
    pulse_cyc.delete();
    pulse_dat.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_data_out",  32'(data_out), 32'h00);
    check_val("rst_valid",     32'(data_valid), 32'd0);
    check_val("rst_frame_err", 32'(frame_err), 32'd0);
    check_val("rst_busy",      32'(busy), 32'd0);
    check_val("rst_state",     32'(debug_state_out), 32'd0);
    check_val("rst_bit_cnt",   32'(debug_bit_cnt_out), 32'd0);
    rst_n = 1'b1;
    idle(6);

    // Single good frame: strobe at edge 78, line idle afterwards.
    clear_pulses();
    send_frame(8'h5A, 1'b1, 1000, 0, 10*OS, t0);
    check_val("5a_npulse", 32'(pulse_cyc.size()), 32'd1);
    if (pulse_cyc.size() >= 1) begin
      check_val("5a_latency", 32'(pulse_cyc[0] - t0), 32'd78);
      check_val("5a_pdata",   32'(pulse_dat[0]), 32'h5A);
    end
    check_val("5a_busy_after", 32'(busy), 32'd0);
    check_val("5a_frame_err",  32'(frame_err), 32'd0);
    check_val("5a_data_out",   32'(data_out), 32'h5A);

    // Back-to-back frames with no idle gap.
    clear_pulses();
    send_frame(8'hC3, 1'b1, 1000, 0, 10*OS, t0);
    send_frame(8'h0F, 1'b1, 1000, 0, 10*OS, t0);
    check_val("b2b_npulse", 32'(pulse_cyc.size()), 32'd2);
    if (pulse_cyc.size() >= 2) begin
      check_val("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd80);
      check_val("b2b_lat2",    32'(pulse_cyc[1] - t0), 32'd78);
      check_val("b2b_data0",   32'(pulse_dat[0]), 32'hC3);
      check_val("b2b_data1",   32'(pulse_dat[1]), 32'h0F);
    end
    check_val("b2b_frame_err", 32'(frame_err), 32'd0);
    idle(4);

    // Two-clock glitch: START entered at edge 2, aborted at the mid-bit check.
    clear_pulses();
    rx_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    check_val("glitch_start", 32'(debug_state_out), 32'd1);
    repeat (8) @(negedge clk);
    check_val("glitch_idle",    32'(debug_state_out), 32'd0);
    check_val("glitch_npulse",  32'(pulse_cyc.size()), 32'd0);
    check_val("glitch_dataout", 32'(data_out), 32'h0F);

    // Low stop bit, then a good frame clears the error.
    clear_pulses();
    send_frame(8'hA5, 1'b0, 1000, 0, 10*OS, t0);
    idle(4);
    check_val("ferr_flag",    32'(frame_err), 32'd1);
    check_val("ferr_npulse",  32'(pulse_cyc.size()), 32'd0);
    check_val("ferr_dataout", 32'(data_out), 32'h0F);
    send_frame(8'h11, 1'b1, 1000, 0, 10*OS, t0);
    check_val("ferr_recover_npulse", 32'(pulse_cyc.size()), 32'd1);
    check_val("ferr_recover_data",   32'(data_out), 32'h11);
    check_val("ferr_recover_flag",   32'(frame_err), 32'd0);
    idle(4);

    // ena low for 5 cycles inside bit 3: strobe slides from edge 78 to 83.
    clear_pulses();
    send_frame(8'h96, 1'b1, 36, 5, 10*OS, t0);
    check_val("stall_npulse", 32'(pulse_cyc.size()), 32'd1);
    if (pulse_cyc.size() >= 1) begin
      check_val("stall_latency", 32'(pulse_cyc[0] - t0), 32'd83);
      check_val("stall_pdata",   32'(pulse_dat[0]), 32'h96);
    end
    check_val("stall_data_out", 32'(data_out), 32'h96);
    idle(4);

    // Reset during data bit 4; the line is held low across release.
    send_frame(8'h3C, 1'b1, 1000, 0, 44, t0);
    check_val("midrst_bitcnt", 32'(debug_bit_cnt_out), 32'd4);
    check_val("midrst_busy",   32'(busy), 32'd1);
    rst_n = 1'b0;
    rx_in = 1'b0;
    #1;
    check_val("midrst_data_out", 32'(data_out), 32'h00);
    check_val("midrst_state",    32'(debug_state_out), 32'd0);
    check_val("midrst_bit_cnt",  32'(debug_bit_cnt_out), 32'd0);
    check_val("midrst_busy0",    32'(busy), 32'd0);
    check_val("midrst_ferr",     32'(frame_err), 32'd0);
    check_val("midrst_valid",    32'(data_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check_val("lowrel_busy", 32'(busy), 32'd0);
    idle(6);
    check_val("lowrel_busy_high", 32'(busy), 32'd0);

    clear_pulses();
    send_frame(8'h3C, 1'b1, 1000, 0, 10*OS, t0);
    check_val("post_rst_npulse", 32'(pulse_cyc.size()), 32'd1);
    if (pulse_cyc.size() >= 1) begin
      check_val("post_rst_latency", 32'(pulse_cyc[0] - t0), 32'd78);
    end
    check_val("post_rst_data", 32'(data_out), 32'h3C);
    check_val("post_rst_ferr", 32'(frame_err), 32'd0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
